// File: rtl/sdm_dac_pkg.sv
// sdm_dac_pkg: shared types and sizing for the delta-sigma DAC slice.
// Contents:
//   W, DIV, DEPTH  default sample width, clocks per sample, FIFO depth
//   div_log2()     ceil(log2) helper for deriving counter and pointer widths
//   state_t        sequencer states IDLE / WAIT / RUN
// Optional feature macro used by the slice: SDM_DAC_INTERP_EN (linear interpolation).
package sdm_dac_pkg;

  localparam int unsigned W     = 8;
  localparam int unsigned DIV   = 8;
  localparam int unsigned DEPTH = 4;

  // Smallest r with 2**r >= value.
  function automatic int unsigned div_log2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned DIV_LOG2 = div_log2(DIV);
  localparam int unsigned PTR_W    = div_log2(DEPTH);
  localparam int unsigned LVL_W    = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/sdm_dac_if.sv
// sdm_dac_if: sample-write bus between a producer (master) and the DAC (slave).
// Signals:
//   din       W      sample data
//   wr        1      write strobe, sample captured when wr && !full
//   full      1      FIFO full (registered)
//   level     LVL_W  FIFO occupancy (registered)
//   overflow  1      1-clk pulse, write attempted while full and dropped
interface sdm_dac_if;
  import sdm_dac_pkg::*;

  logic [W-1:0]     din;
  logic             wr;
  logic             full;
  logic [LVL_W-1:0] level;
  logic             overflow;

  modport master (
    output din,
    output wr,
    input  full,
    input  level,
    input  overflow
  );

  modport slave (
    input  din,
    input  wr,
    output full,
    output level,
    output overflow
  );

endinterface

// File: rtl/sdm_dac_fifo.sv
// sdm_dac_fifo: small synchronous sample FIFO with registered full/level/overflow.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset (flushes the FIFO)
//   wr_i, din_i   write strobe and data; accepted when the registered full is low
//   pop_i         consume the head entry (ignored when empty)
//   head_c_o      combinational view of the head entry
//   full_o        registered full flag
//   level_o       registered occupancy
//   overflow_o    registered 1-clk pulse for a write dropped while full
module sdm_dac_fifo
  import sdm_dac_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_i,
  input  logic [W-1:0]     din_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_c_o,
  output logic             full_o,
  output logic [LVL_W-1:0] level_o,
  output logic             overflow_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, overflow_q;
  logic             wr_ok_c, pop_ok_c;

  // Full is the registered flag, so a write into a full FIFO is dropped
  // even when a pop happens on the same edge.
  assign wr_ok_c  = wr_i && !full_q;
  assign pop_ok_c = pop_i && (level_q != '0);

  // Occupancy next-state; simultaneous write and pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    case ({wr_ok_c, pop_ok_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers and status flags; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ok_c)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q    <= level_d;
      full_q     <= (level_d == LVL_W'(DEPTH));
      overflow_q <= wr_i && full_q;
    end
  end

  assign head_c_o   = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/sdm_dac.sv
// sdm_dac: first-order delta-sigma DAC. Samples arrive over sdm_dac_if into a
// small FIFO and are consumed one per DIV clocks; each clock in RUN the
// accumulator adds the current sample and its carry-out is the 1-bit output.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   en            run enable (level); low forces IDLE and dac_out=0
//   bus           sdm_dac_if.slave: din/wr in, full/level/overflow out
//   dac_out       registered delta-sigma bit stream
//   underrun      registered 1-clk pulse when a sample tick finds the FIFO empty
// Build option: define SDM_DAC_INTERP_EN to linearly interpolate between the
// previous and current sample across each DIV-clock period.
module sdm_dac
  import sdm_dac_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     en,
  sdm_dac_if.slave bus,
  output logic     dac_out,
  output logic     underrun
);

`ifdef SDM_DAC_INTERP_EN
  localparam int unsigned AW = W + DIV_LOG2;
`else
  localparam int unsigned AW = W;
`endif
  localparam int unsigned CNT_W = DIV_LOG2;

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic [W-1:0]     cur_q;
  logic [AW-1:0]    acc_q;
  logic             dac_q, underrun_q;

  logic [W-1:0]     head_c;
  logic [AW-1:0]    x_c, acc_d;
  logic             carry_d;
  logic             empty_c, tick_c, pop_c;

  assign empty_c = (bus.level == '0);
  assign tick_c  = (count_q == CNT_W'(DIV - 1));
  assign pop_c   = en && !empty_c &&
                   ((state_q == WAIT) || ((state_q == RUN) && tick_c));

  sdm_dac_fifo u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_i       (bus.wr),
    .din_i      (bus.din),
    .pop_i      (pop_c),
    .head_c_o   (head_c),
    .full_o     (bus.full),
    .level_o    (bus.level),
    .overflow_o (bus.overflow)
  );

`ifdef SDM_DAC_INTERP_EN
  localparam int unsigned SW = AW + 2;

  logic [W-1:0]         prev_q;
  logic signed [SW-1:0] base_s, diff_s, cnt_s, x_s;

  // x = prev*DIV + (cur-prev)*count; the signed slope keeps falling ramps
  // correct, and the sum always lands in [0, 2**AW).
  always_comb begin
    base_s = $signed(SW'({prev_q, CNT_W'(0)}));
    diff_s = $signed(SW'(cur_q)) - $signed(SW'(prev_q));
    cnt_s  = $signed(SW'(count_q));
    x_s    = base_s + diff_s * cnt_s;
    x_c    = AW'(x_s);
  end
`else
  assign x_c = cur_q;
`endif

  // Modulator step: carry-out of the accumulator is the output bit.
  assign {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, x_c};

  // Sequencer, sample divider and modulator registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      cur_q      <= '0;
      acc_q      <= '0;
      dac_q      <= 1'b0;
      underrun_q <= 1'b0;
`ifdef SDM_DAC_INTERP_EN
      prev_q     <= '0;
`endif
    end else begin
      underrun_q <= 1'b0;
      if (!en) begin
        state_q <= IDLE;
        count_q <= '0;
        acc_q   <= '0;
        dac_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= WAIT;
            count_q <= '0;
            acc_q   <= '0;
            dac_q   <= 1'b0;
          end
          WAIT: begin
            count_q <= '0;
            dac_q   <= 1'b0;
            if (!empty_c) begin
              cur_q   <= head_c;
`ifdef SDM_DAC_INTERP_EN
              prev_q  <= cur_q;
`endif
              state_q <= RUN;
            end
          end
          RUN: begin
            acc_q   <= acc_d;
            dac_q   <= carry_d;
            count_q <= count_q + CNT_W'(1);
            // Sample tick: take the next sample, or keep the old one on underrun.
            if (tick_c) begin
              if (!empty_c) begin
                cur_q  <= head_c;
`ifdef SDM_DAC_INTERP_EN
                prev_q <= cur_q;
`endif
              end else begin
                underrun_q <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dac_out  = dac_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_sdm_dac.sv
// tb_sdm_dac: self-checking bench for sdm_dac. A cycle-level behavioural model
// (queue FIFO, integer accumulator) predicts every output each clock; directed
// phases add ones-density, full/overflow, underrun, en-drop and reset checks,
// followed by a randomized phase.
module tb_sdm_dac;
  import sdm_dac_pkg::*;

`ifdef SDM_DAC_INTERP_EN
  localparam int unsigned AW     = W + DIV_LOG2;
  localparam bit          INTERP = 1'b1;
`else
  localparam int unsigned AW     = W;
  localparam bit          INTERP = 1'b0;
`endif
  localparam int unsigned MOD = 2 ** AW;

  logic clk = 1'b0;
  logic reset_n;
  logic en;
  logic dac_out;
  logic underrun;

  sdm_dac_if bus ();

  sdm_dac dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .bus      (bus),
    .dac_out  (dac_out),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ones_cnt = 0;

  // Reference model state: 0 idle, 1 waiting for data, 2 running.
  logic [W-1:0] m_q[$];
  int           m_mode;
  int unsigned  m_phase, m_cur, m_prev, m_acc;
  bit           m_dac, m_und, m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
    end
  endtask

  // One clock of the reference model, using the inputs the DUT samples.
  task automatic model_clock();
    int  pre;
    int  xs;
    int unsigned x, s;
    bit  do_pop;
    pre    = m_q.size();
    do_pop = 1'b0;
    m_und  = 1'b0;
    m_ovf  = bus.wr && (pre == int'(DEPTH));
    if (!reset_n) begin
      m_q.delete();
      m_mode = 0; m_phase = 0; m_cur = 0; m_prev = 0; m_acc = 0;
      m_dac = 1'b0; m_ovf = 1'b0;
      return;
    end
    if (!en) begin
      m_mode = 0; m_phase = 0; m_acc = 0; m_dac = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_dac = 1'b0;
    end else if (m_mode == 1) begin
      m_dac = 1'b0; m_phase = 0;
      if (pre > 0) begin do_pop = 1'b1; m_mode = 2; end
    end else begin
      xs = int'(m_prev) * int'(DIV) + (int'(m_cur) - int'(m_prev)) * int'(m_phase);
      x  = INTERP ? 32'(xs) : m_cur;
      s  = m_acc + x;
      m_dac = (s >= MOD);
      m_acc = s % MOD;
      if (m_phase == DIV - 1) begin
        if (pre > 0) do_pop = 1'b1;
        else         m_und  = 1'b1;
      end
      m_phase = (m_phase + 1) % DIV;
    end
    if (do_pop) begin
      m_prev = m_cur;
      m_cur  = 32'(m_q.pop_front());
    end
    if (bus.wr && (pre < int'(DEPTH))) m_q.push_back(bus.din);
  endtask

  // Advance one clock, update the model, then compare all outputs.
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_eq("dac_out",  32'(dac_out),      32'(m_dac));
    check_eq("level",    32'(bus.level),    32'(m_q.size()));
    check_eq("full",     32'(bus.full),     32'(m_q.size() == int'(DEPTH)));
    check_eq("underrun", 32'(underrun),     32'(m_und));
    check_eq("overflow", 32'(bus.overflow), 32'(m_ovf));
    ones_cnt += int'(dac_out);
  endtask

  // Keep the FIFO topped up with one value for n clocks.
  task automatic feed(input logic [W-1:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      bus.wr  = (m_q.size() < int'(DEPTH));
      bus.din = val;
      step();
    end
    bus.wr = 1'b0;
  endtask

  initial begin
    int lvl_before;
    bit seen;
    reset_n = 1'b0; en = 1'b0; bus.wr = 1'b0; bus.din = '0;
    m_mode = 0; m_phase = 0; m_cur = 0; m_prev = 0; m_acc = 0;
    m_dac = 1'b0; m_und = 1'b0; m_ovf = 1'b0;

    // Reset state.
    repeat (2) step();
    check_eq("rst_level", 32'(bus.level), 32'd0);
    check_eq("rst_full",  32'(bus.full),  32'd0);
    check_eq("rst_dac",   32'(dac_out),   32'd0);
    reset_n = 1'b1;
    step();

    // Fill with en low: full after the 4th write, 5th is dropped.
    for (int i = 0; i < 5; i++) begin
      bus.wr = 1'b1; bus.din = W'(8'h10 + i);
      step();
      if (i == 3) check_eq("full_after_4", 32'(bus.full), 32'd1);
      if (i == 4) begin
        check_eq("overflow_5th", 32'(bus.overflow), 32'd1);
        check_eq("level_5th",    32'(bus.level),    32'(DEPTH));
      end
    end
    bus.wr = 1'b0;
    repeat (3) step();
    check_eq("fifo_kept_en0", 32'(bus.level), 32'(DEPTH));

    // Density 0x40: 64 ones per 256 clocks once settled.
    en = 1'b1;
    feed(8'h40, 400);
    ones_cnt = 0;
    feed(8'h40, 256);
    check_eq("density_40", 32'(ones_cnt), 32'd64);

    // Density 0x00: no ones at all.
    feed(8'h00, 100);
    ones_cnt = 0;
    feed(8'h00, 256);
    check_eq("density_00", 32'(ones_cnt), 32'd0);

    // Drain to empty, then two lone 0x80 samples and an underrun.
    repeat (64) step();
    bus.wr = 1'b1; bus.din = 8'h80; step();
    bus.wr = 1'b0; repeat (10) step();
    bus.wr = 1'b1; bus.din = 8'h80; step();
    bus.wr = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = underrun;
    end
    check_eq("underrun_seen", 32'(seen), 32'd1);
    ones_cnt = 0;
    repeat (256) step();
    check_eq("density_80_held", 32'(ones_cnt), 32'd128);

    // en drop mid-RUN: output off next clock, FIFO contents preserved.
    bus.wr = 1'b1; bus.din = 8'h55; step();
    bus.din = 8'h66; step();
    bus.wr = 1'b0;
    lvl_before = m_q.size();
    en = 1'b0;
    step();
    check_eq("endrop_dac",   32'(dac_out),   32'd0);
    check_eq("endrop_level", 32'(bus.level), 32'(lvl_before));
    repeat (5) step();
    en = 1'b1;
    repeat (40) step();

    // Randomized traffic with occasional en drops and resets.
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 31) != 0);
      reset_n = ($urandom_range(0, 499) != 0);
      bus.wr  = ($urandom_range(0, 5) == 0);
      bus.din = W'($urandom);
      step();
    end
    reset_n = 1'b1; en = 1'b1; bus.wr = 1'b0;

    // Reset mid-run flushes the FIFO and silences the output.
    feed(8'hC3, 30);
    bus.wr = 1'b1; bus.din = 8'h11; step();
    bus.wr = 1'b0;
    reset_n = 1'b0;
    repeat (2) step();
    check_eq("midrst_level", 32'(bus.level), 32'd0);
    check_eq("midrst_full",  32'(bus.full),  32'd0);
    check_eq("midrst_dac",   32'(dac_out),   32'd0);
    reset_n = 1'b1;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
